// File: rtl/jt51_wr_sched_pkg.sv
// Shared types, YM2151 register-map constants and the address decoder for the JT51 host write path.
package jt51_wr_sched_pkg;

   localparam logic [7:0] KEYON      = 8'h08;
   localparam logic [7:0] RL_BASE    = 8'h20;
   localparam logic [7:0] KC_BASE    = 8'h28;
   localparam logic [7:0] KF_BASE    = 8'h30;
   localparam logic [7:0] PMS_BASE   = 8'h38;
   localparam logic [7:0] DT1_BASE   = 8'h40;
   localparam logic [7:0] TL_BASE    = 8'h60;
   localparam logic [7:0] KS_BASE    = 8'h80;
   localparam logic [7:0] AMSEN_BASE = 8'hA0;
   localparam logic [7:0] DT2_BASE   = 8'hC0;
   localparam logic [7:0] D1L_BASE   = 8'hE0;

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GLB} state_e;

   typedef enum logic [3:0] {
      FLD_NONE, FLD_RL, FLD_KC, FLD_KF, FLD_PMS, FLD_DT1, FLD_TL,
      FLD_KS, FLD_AMSEN, FLD_DT2, FLD_D1L, FLD_KEYON, FLD_GLB
   } field_e;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } entry_t;

   function automatic logic is_glb(input logic [7:0] a);
      case (a)
         8'h01, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h18, 8'h19, 8'h1B: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Ranges are checked from the top down so each test only needs the lower bound.
   function automatic field_e decode_addr(input logic [7:0] a);
      if (a >= D1L_BASE)        return FLD_D1L;
      else if (a >= DT2_BASE)   return FLD_DT2;
      else if (a >= AMSEN_BASE) return FLD_AMSEN;
      else if (a >= KS_BASE)    return FLD_KS;
      else if (a >= TL_BASE)    return FLD_TL;
      else if (a >= DT1_BASE)   return FLD_DT1;
      else if (a >= PMS_BASE)   return FLD_PMS;
      else if (a >= KF_BASE)    return FLD_KF;
      else if (a >= KC_BASE)    return FLD_KC;
      else if (a >= RL_BASE)    return FLD_RL;
      else if (a == KEYON)      return FLD_KEYON;
      else if (is_glb(a))       return FLD_GLB;
      else                      return FLD_NONE;
   endfunction

endpackage

// File: rtl/jt51_wr_sched_if.sv
// CPU-side bus and register-block update port of the JT51 write scheduler.
interface jt51_wr_sched_if;
   logic       wr;
   logic       a0;
   logic [7:0] cpu_din;
   logic       busy;
   logic       wr_lost;
   logic       idle;
   logic [7:0] dout;
   logic [1:0] op;
   logic [2:0] ch;
   logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl;
   logic       up_ks, up_amsen, up_dt2, up_d1l, up_keyon;
   logic       up_glb;
   logic [7:0] glb_addr;

   modport master (
      output wr, a0, cpu_din,
      input  busy, wr_lost, idle, dout, op, ch,
      input  up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl,
      input  up_ks, up_amsen, up_dt2, up_d1l, up_keyon, up_glb, glb_addr
   );

   modport slave (
      input  wr, a0, cpu_din,
      output busy, wr_lost, idle, dout, op, ch,
      output up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl,
      output up_ks, up_amsen, up_dt2, up_d1l, up_keyon, up_glb, glb_addr
   );
endinterface

// File: rtl/jt51_wr_fifo.sv
// Small synchronous FIFO holding queued {addr,data} host writes; head entry readable without a pop.
module jt51_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   // Fullness is the pre-edge value, so a same-cycle pop never makes room for a push.
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end
endmodule

// File: rtl/jt51_wr_sched.sv
// JT51 host write scheduler: queues CPU writes, decodes them into field strobes and holds each
// strobe for a full 32-slot operator rotation so the slot-matched register update lands.
//
// state   | meaning
// ST_IDLE | no commit; pops the FIFO head when one is waiting
// ST_HOLD | field strobe high, counting 32 cen edges
// ST_GLB  | up_glb high for a single clk
module jt51_wr_sched
   import jt51_wr_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic cen,
   jt51_wr_sched_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [7:0]    addr_lat;
   logic          lost_q;
   logic          push, pop;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   entry_t        head;
   field_e        dec;

   state_e     state, state_nx;
   field_e     fld, fld_nx;
   logic [4:0] cnt, cnt_nx;
   logic [7:0] dout_q, dout_nx;
   logic [1:0] op_q, op_nx;
   logic [2:0] ch_q, ch_nx;
   logic [7:0] glb_q, glb_nx;

   assign push = bus.wr & bus.a0;

   jt51_wr_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({addr_lat, bus.cpu_din}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_lat <= '0;
         lost_q   <= 1'b0;
      end else begin
         if (bus.wr & ~bus.a0) addr_lat <= bus.cpu_din;
         lost_q <= push & fifo_full;
      end
   end

   assign dec = decode_addr(head.addr);

   always_comb begin
      state_nx = state;
      fld_nx   = fld;
      cnt_nx   = cnt;
      dout_nx  = dout_q;
      op_nx    = op_q;
      ch_nx    = ch_q;
      glb_nx   = glb_q;
      pop      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (dec == FLD_GLB) begin
                  state_nx = ST_GLB;
                  glb_nx   = head.addr;
                  dout_nx  = head.data;
                  op_nx    = '0;
                  ch_nx    = '0;
               end else if (dec != FLD_NONE) begin
                  state_nx = ST_HOLD;
                  fld_nx   = dec;
                  cnt_nx   = '0;
                  dout_nx  = head.data;
                  // Channel registers and key-on carry no operator; key-on's channel rides in the data.
                  op_nx    = (dec inside {FLD_RL, FLD_KC, FLD_KF, FLD_PMS, FLD_KEYON}) ? 2'd0 : head.addr[4:3];
                  ch_nx    = (dec == FLD_KEYON) ? 3'd0 : head.addr[2:0];
               end
            end
         end
         ST_HOLD: begin
            if (cen) begin
               cnt_nx = cnt + 5'd1;
               if (cnt == 5'd31) state_nx = ST_IDLE;
            end
         end
         ST_GLB:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         fld    <= FLD_NONE;
         cnt    <= '0;
         dout_q <= '0;
         op_q   <= '0;
         ch_q   <= '0;
         glb_q  <= '0;
      end else begin
         state  <= state_nx;
         fld    <= fld_nx;
         cnt    <= cnt_nx;
         dout_q <= dout_nx;
         op_q   <= op_nx;
         ch_q   <= ch_nx;
         glb_q  <= glb_nx;
      end
   end

   logic hold;
   assign hold = state == ST_HOLD;

   assign bus.up_rl    = hold && fld == FLD_RL;
   assign bus.up_kc    = hold && fld == FLD_KC;
   assign bus.up_kf    = hold && fld == FLD_KF;
   assign bus.up_pms   = hold && fld == FLD_PMS;
   assign bus.up_dt1   = hold && fld == FLD_DT1;
   assign bus.up_tl    = hold && fld == FLD_TL;
   assign bus.up_ks    = hold && fld == FLD_KS;
   assign bus.up_amsen = hold && fld == FLD_AMSEN;
   assign bus.up_dt2   = hold && fld == FLD_DT2;
   assign bus.up_d1l   = hold && fld == FLD_D1L;
   assign bus.up_keyon = hold && fld == FLD_KEYON;
   assign bus.up_glb   = state == ST_GLB;
   assign bus.glb_addr = glb_q;
   assign bus.dout     = dout_q;
   assign bus.op       = op_q;
   assign bus.ch       = ch_q;
   assign bus.busy     = fifo_count == CW'(DEPTH);
   assign bus.wr_lost  = lost_q;
   assign bus.idle     = fifo_empty && state == ST_IDLE;
endmodule

// File: tb/tb_jt51_wr_sched.sv
// Bench for jt51_wr_sched: directed scenarios plus random traffic, every cycle compared against a
// queue-based model of the scheduler built from the register map and hold-time rules.
module tb_jt51_wr_sched;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cen = 1'b1;
   int   cen_mode = 0;

   jt51_wr_sched_if bus();

   jt51_wr_sched #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .cen (cen),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      case (cen_mode)
         0:       cen = 1'b1;
         1:       cen = ~cen;
         default: cen = 1'($urandom_range(0, 1));
      endcase
   end

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // strobe bit order: 10=rl 9=kc 8=kf 7=pms 6=dt1 5=tl 4=ks 3=amsen 2=dt2 1=d1l 0=keyon
   function automatic logic [10:0] dut_up();
      return {bus.up_rl, bus.up_kc, bus.up_kf, bus.up_pms, bus.up_dt1, bus.up_tl,
              bus.up_ks, bus.up_amsen, bus.up_dt2, bus.up_d1l, bus.up_keyon};
   endfunction

   int unsigned lo_tab[10] = '{'h20, 'h28, 'h30, 'h38, 'h40, 'h60, 'h80, 'hA0, 'hC0, 'hE0};
   int unsigned hi_tab[10] = '{'h27, 'h2F, 'h37, 'h3F, 'h5F, 'h7F, 'h9F, 'hBF, 'hDF, 'hFF};

   // -2 global, -1 discarded, else strobe bit index
   function automatic int classify(input logic [7:0] a);
      if (a == 8'h08) return 0;
      case (a)
         8'h01, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h18, 8'h19, 8'h1B: return -2;
         default: ;
      endcase
      for (int i = 0; i < 10; i++)
         if (a >= lo_tab[i] && a <= hi_tab[i]) return 10 - i;
      return -1;
   endfunction

   // reference model
   logic [15:0] m_q[$];
   int          m_rem;
   bit          m_glb;
   logic [10:0] m_vec;
   logic [7:0]  m_dout, m_glb_addr, m_latch;
   logic [1:0]  m_op;
   logic [2:0]  m_ch;
   bit          m_lost;
   bit          m_full_pre;
   logic [15:0] m_e;
   int          m_k;

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_rem = 0; m_glb = 0; m_vec = '0; m_dout = '0; m_glb_addr = '0;
         m_latch = '0; m_op = '0; m_ch = '0; m_lost = 0;
      end else begin
         m_full_pre = (m_q.size() == DEPTH);
         if (m_rem > 0) begin
            if (cen) m_rem--;
         end else if (m_glb) begin
            m_glb = 0;
         end else if (m_q.size() > 0) begin
            m_e = m_q.pop_front();
            m_k = classify(m_e[15:8]);
            if (m_k == -2) begin
               m_glb = 1; m_glb_addr = m_e[15:8]; m_dout = m_e[7:0]; m_op = '0; m_ch = '0;
            end else if (m_k >= 0) begin
               m_rem = 32;
               m_vec = '0;
               m_vec[m_k] = 1'b1;
               m_dout = m_e[7:0];
               m_op = (m_e[15:8] >= 8'h40) ? m_e[12:11] : 2'd0;
               m_ch = (m_k == 0) ? 3'd0 : m_e[10:8];
            end
         end
         m_lost = bus.wr && bus.a0 && m_full_pre;
         if (bus.wr && bus.a0 && !m_full_pre) m_q.push_back({m_latch, bus.cpu_din});
         if (bus.wr && !bus.a0) m_latch = bus.cpu_din;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk_eq("flags", {bus.busy, bus.wr_lost, bus.idle},
                {m_q.size() == DEPTH, m_lost, m_q.size() == 0 && m_rem == 0 && !m_glb});
         chk_eq("strobes", {dut_up(), bus.up_glb}, {(m_rem > 0) ? m_vec : 11'd0, m_glb});
         chk_eq("fields", {bus.dout, bus.op, bus.ch, bus.glb_addr}, {m_dout, m_op, m_ch, m_glb_addr});
      end
   end

   task automatic drive(input bit w, input bit a, input logic [7:0] d);
      @(posedge clk);
      #1;
      bus.wr = w; bus.a0 = a; bus.cpu_din = d;
   endtask

   task automatic write(input logic [7:0] a, input logic [7:0] d);
      drive(1, 0, a);
      drive(1, 1, d);
      drive(0, 0, 8'h00);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.idle) break;
      end
      chk_eq("idle_reached", bus.idle, 1);
   endtask

   // waits for a strobe in mask, returns its length in clk and the fields seen on its first cycle
   task automatic measure(input logic [10:0] mask, output int len,
                          output logic [7:0] d0, output logic [1:0] o0, output logic [2:0] c0);
      bit seen = 0;
      len = 0; d0 = '0; o0 = '0; c0 = '0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if ((dut_up() & mask) != 0) seen = 1;
      end
      chk_eq("strobe_seen", seen, 1);
      if (seen) begin
         d0 = bus.dout; o0 = bus.op; c0 = bus.ch;
         while ((dut_up() & mask) != 0 && len < 300) begin
            len++;
            @(negedge clk);
         end
      end
   endtask

   logic [7:0] addr_set[16] = '{8'h08, 8'h01, 8'h0F, 8'h14, 8'h1B, 8'h02, 8'h1F, 8'h20,
                                8'h2F, 8'h3F, 8'h40, 8'h7F, 8'h9B, 8'hBF, 8'hDF, 8'hFF};

   int         len, r;
   logic [7:0] d0, ga;
   logic [1:0] o0;
   logic [2:0] c0;
   bit         seen;

   initial begin
      bus.wr = 0; bus.a0 = 0; bus.cpu_din = '0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk_en = 1;
      @(negedge clk);
      chk_eq("rst_idle", bus.idle, 1);
      chk_eq("rst_busy", bus.busy, 0);
      chk_eq("rst_strobes", {dut_up(), bus.up_glb}, 0);

      // kc commit, cen every clk
      cen_mode = 0;
      write(8'h28, 8'h4A);
      measure(11'h200, len, d0, o0, c0);
      chk_eq("kc_len", len, 32);
      chk_eq("kc_dout", d0, 8'h4A);
      chk_eq("kc_opch", {o0, c0}, 0);
      wait_idle(10);

      // dt1 commit with cen 1-in-2
      cen_mode = 1;
      write(8'h5B, 8'h71);
      measure(11'h040, len, d0, o0, c0);
      chk_eq("dt1_len_64", (len >= 63 && len <= 64), 1);
      chk_eq("dt1_op", o0, 3);
      chk_eq("dt1_ch", c0, 3);
      chk_eq("dt1_dout", d0, 8'h71);
      wait_idle(20);

      // burst of five data writes during a commit
      cen_mode = 0;
      write(8'h20, 8'h11);
      drive(1, 0, 8'h30);
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 8'hA0 + 8'(i));
         if (i == 4) begin
            @(negedge clk);
            chk_eq("busy_after_4", bus.busy, 1);
         end
      end
      drive(0, 0, 8'h00);
      @(negedge clk);
      chk_eq("wr_lost_5th", bus.wr_lost, 1);
      wait_idle(600);

      // global write then a discarded address
      write(8'h14, 8'h15);
      seen = 0; len = 0; ga = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.up_glb) begin
            if (!seen) ga = bus.glb_addr;
            seen = 1;
            len++;
         end
      end
      chk_eq("glb_len", len, 1);
      chk_eq("glb_addr", ga, 8'h14);
      write(8'h02, 8'hFF);
      wait_idle(10);
      repeat (3) @(negedge clk);
      chk_eq("discard_quiet", {dut_up(), bus.up_glb, bus.idle}, 1);

      // key-on aborted by reset at cnt 10
      write(8'h08, 8'h7A);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = bus.up_keyon;
      end
      chk_eq("kon_seen", seen, 1);
      chk_eq("kon_dout", bus.dout, 8'h7A);
      repeat (10) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk_eq("kon_rst_strobe", bus.up_keyon, 0);
      chk_eq("kon_rst_flags", {bus.busy, bus.idle}, 2'b01);

      // address write while busy feeds the next accepted data write
      write(8'h38, 8'h01);
      drive(1, 0, 8'h40);
      for (int i = 0; i < 4; i++) drive(1, 1, 8'(i + 1));
      drive(1, 0, 8'hE5);
      drive(0, 0, 8'h00);
      @(negedge clk);
      chk_eq("busy_at_latch", bus.busy, 1);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
      end
      chk_eq("unbusy", bus.busy, 0);
      drive(1, 1, 8'h99);
      drive(0, 0, 8'h00);
      seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = bus.up_d1l;
      end
      chk_eq("d1l_seen", seen, 1);
      chk_eq("d1l_ch_dout", {bus.ch, bus.op, bus.dout}, {3'd5, 2'd0, 8'h99});
      wait_idle(300);

      // random traffic with random cen and occasional reset
      cen_mode = 2;
      for (int i = 0; i < 2500; i++) begin
         r = int'($urandom_range(0, 399));
         @(posedge clk);
         #1;
         rst = (r == 0);
         if (r > 0 && r < 120) begin
            bus.wr = 1; bus.a0 = 0;
            bus.cpu_din = ($urandom_range(0, 1) == 1) ? addr_set[$urandom_range(0, 15)] : 8'($urandom);
         end else if (r >= 120 && r < 240) begin
            bus.wr = 1; bus.a0 = 1; bus.cpu_din = 8'($urandom);
         end else begin
            bus.wr = 0; bus.a0 = 0; bus.cpu_din = '0;
         end
      end
      drive(0, 0, 8'h00);
      rst = 0;
      wait_idle(1500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
